// File: rtl/parser_conf_arbiter.sv
// Purpose : round-robin arbiter granting config requesters access to per-layer parser rule tables.
// Latency : strobe 1 cycle after accept, response 2 cycles after accept (+k for late read returns).
// Backpress: one transaction outstanding; o_req_ready only pulses in IDLE, requesters hold until ready.
//
// Ports:
//   i_clk/i_rst              clock, async active-high reset
//   i_req_*/o_req_ready      per-requester request channel (valid, wr, addr, wdata) and accept strobe
//   o_resp_*                 one-hot completion strobe with shared err/rdata
//   o_rule_*/i_rule_rdata*   per-layer rule-table strobes, shared addr/wdata, per-layer read returns
//   o_busy                   high whenever a transaction is in flight
module parser_conf_arbiter #(
   parameter int REQ_NUM   = 2,
   parameter int LAYER_NUM = 4,
   parameter int TIMEOUT   = 15
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [REQ_NUM-1:0]          i_req_valid,
   input  logic [REQ_NUM-1:0]          i_req_wr,
   input  logic [REQ_NUM-1:0][31:0]    i_req_addr,
   input  logic [REQ_NUM-1:0][31:0]    i_req_wdata,
   output logic [REQ_NUM-1:0]          o_req_ready,
   output logic [REQ_NUM-1:0]          o_resp_valid,
   output logic                        o_resp_err,
   output logic [31:0]                 o_resp_rdata,
   output logic [LAYER_NUM-1:0]        o_rule_wren,
   output logic [LAYER_NUM-1:0]        o_rule_rden,
   output logic [31:0]                 o_rule_addr,
   output logic [31:0]                 o_rule_wdata,
   input  logic [LAYER_NUM-1:0]        i_rule_rdata_valid,
   input  logic [LAYER_NUM-1:0][31:0]  i_rule_rdata,
   output logic                        o_busy
);

   localparam int          GW       = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [GW-1:0] r_rr_ptr;
   logic [GW-1:0] r_grant;
   logic          r_wr;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_cnt;
   logic          r_resp_err;
   logic [31:0]   r_resp_rdata;

   logic [GW-1:0] w_grant;
   logic          w_any;
   int            w_idx;
   logic [3:0]    w_layer;
   logic          w_layer_ok;
   logic          w_rd_hit;
   logic [31:0]   w_rd_data;
   logic          w_timeout;

   assign w_layer    = r_addr[31:28];
   assign w_layer_ok = (int'(w_layer) < LAYER_NUM);
   // Counter value after this cycle would reach TIMEOUT: last cycle a return can still be taken.
   assign w_timeout  = ((int'(r_cnt) + 1) >= TIMEOUT);

   // Round-robin search starting at r_rr_ptr.
   always_comb begin
      w_any   = 1'b0;
      w_grant = r_rr_ptr;
      w_idx   = 0;
      for (int i = 0; i < REQ_NUM; i++) begin
         w_idx = (int'(r_rr_ptr) + i) % REQ_NUM;
         if (!w_any && i_req_valid[w_idx]) begin
            w_any   = 1'b1;
            w_grant = GW'(w_idx);
         end
      end
   end

   // Only the addressed layer's return is looked at.
   always_comb begin
      w_rd_hit  = 1'b0;
      w_rd_data = '0;
      for (int l = 0; l < LAYER_NUM; l++) begin
         if (l == int'(w_layer) && i_rule_rdata_valid[l]) begin
            w_rd_hit  = 1'b1;
            w_rd_data = i_rule_rdata[l];
         end
      end
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; a return beats the timeout in the same cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_any) w_next = S_ISSUE;
         S_ISSUE: begin
            if (!w_layer_ok || r_wr || w_rd_hit || TIMEOUT <= 1) w_next = S_RESP;
            else                                                 w_next = S_WAIT_RD;
         end
         S_WAIT_RD: if (w_rd_hit || w_timeout) w_next = S_RESP;
         S_RESP:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Outputs; ready is gated by reset so nothing is accepted while reset is held.
   always_comb begin
      o_req_ready  = '0;
      o_rule_wren  = '0;
      o_rule_rden  = '0;
      o_resp_valid = '0;
      if (r_state == S_IDLE && w_any && !i_rst) o_req_ready[w_grant] = 1'b1;
      if (r_state == S_ISSUE && w_layer_ok) begin
         for (int l = 0; l < LAYER_NUM; l++) begin
            if (l == int'(w_layer)) begin
               o_rule_wren[l] = r_wr;
               o_rule_rden[l] = !r_wr;
            end
         end
      end
      if (r_state == S_RESP) o_resp_valid[r_grant] = 1'b1;
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_rule_addr  = {4'b0, r_addr[27:0]};
   assign o_rule_wdata = r_wdata;
   assign o_resp_err   = r_resp_err;
   assign o_resp_rdata = r_resp_rdata;

   // Transaction context, wait counter and response registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr_ptr     <= '0;
         r_grant      <= '0;
         r_wr         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cnt        <= '0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant <= w_grant;
                  r_wr    <= i_req_wr[w_grant];
                  r_addr  <= i_req_addr[w_grant];
                  r_wdata <= i_req_wdata[w_grant];
               end
            end
            S_ISSUE: begin
               r_cnt <= 4'd1;
               if (!w_layer_ok) begin
                  r_resp_err   <= 1'b1;
                  r_resp_rdata <= ERR_DATA;
               end else if (r_wr) begin
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= '0;
               end else if (w_rd_hit) begin
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= w_rd_data;
               end else if (TIMEOUT <= 1) begin
                  r_resp_err   <= 1'b1;
                  r_resp_rdata <= ERR_DATA;
               end
            end
            S_WAIT_RD: begin
               r_cnt <= r_cnt + 4'd1;
               if (w_rd_hit) begin
                  r_resp_err   <= 1'b0;
                  r_resp_rdata <= w_rd_data;
               end else if (w_timeout) begin
                  r_resp_err   <= 1'b1;
                  r_resp_rdata <= ERR_DATA;
               end
            end
            S_RESP: begin
               r_cnt <= '0;
               if (int'(r_grant) == REQ_NUM - 1) r_rr_ptr <= '0;
               else                              r_rr_ptr <= r_grant + 1'b1;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_parser_conf_arbiter.sv
// Purpose : self-checking bench for parser_conf_arbiter against a transaction-level model.
// Latency : each transaction is checked cycle by cycle from accept to the cycle after response.
// Backpress: requesters may hold valid through a transaction; ready must stay low while busy.
module tb_parser_conf_arbiter;

    localparam int          TIMEOUT = 15;
    localparam logic [31:0] DEAD    = 32'hDEADBEEF;

    logic              i_clk;
    logic              i_rst;
    logic [1:0]        i_req_valid;
    logic [1:0]        i_req_wr;
    logic [1:0][31:0]  i_req_addr;
    logic [1:0][31:0]  i_req_wdata;
    logic [1:0]        o_req_ready;
    logic [1:0]        o_resp_valid;
    logic              o_resp_err;
    logic [31:0]       o_resp_rdata;
    logic [3:0]        o_rule_wren;
    logic [3:0]        o_rule_rden;
    logic [31:0]       o_rule_addr;
    logic [31:0]       o_rule_wdata;
    logic [3:0]        i_rule_rdata_valid;
    logic [3:0][31:0]  i_rule_rdata;
    logic              o_busy;

    int errors = 0;
    int checks = 0;
    int m_rr   = 0;

    logic        t_wr[2];
    logic [31:0] t_addr[2];
    logic [31:0] t_wdata[2];

    parser_conf_arbiter #(.REQ_NUM(2), .LAYER_NUM(4), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .i_req_wr(i_req_wr),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid),
        .o_resp_err(o_resp_err), .o_resp_rdata(o_resp_rdata),
        .o_rule_wren(o_rule_wren), .o_rule_rden(o_rule_rden),
        .o_rule_addr(o_rule_addr), .o_rule_wdata(o_rule_wdata),
        .i_rule_rdata_valid(i_rule_rdata_valid), .i_rule_rdata(i_rule_rdata),
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_tables();
        for (int k = 0; k < 2; k++) begin
            i_req_wr[k]    = t_wr[k];
            i_req_addr[k]  = t_addr[k];
            i_req_wdata[k] = t_wdata[k];
        end
    endtask

    task automatic txn(input logic [1:0] vmask, input bit hold, input int dly,
                       input logic [31:0] rdat, input bit noise);
        int          g;
        int          idx;
        int          lay;
        int          resp_at;
        bit          wr;
        logic [31:0] a;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [1:0]  exp_g;
        logic [3:0]  exp_wr;
        logic [3:0]  exp_rdn;
        g = 0;
        idx = 0;
        for (int i = 1; i >= 0; i--) begin
            idx = (m_rr + i) % 2;
            if (vmask[idx]) g = idx;
        end
        wr  = t_wr[g];
        a   = t_addr[g];
        lay = int'(a[31:28]);
        if (lay >= 4)                         begin exp_err = 1; exp_rd = DEAD; resp_at = 2;           end
        else if (wr)                          begin exp_err = 0; exp_rd = '0;   resp_at = 2;           end
        else if (dly >= 0 && dly < TIMEOUT)   begin exp_err = 0; exp_rd = rdat; resp_at = 2 + dly;     end
        else                                  begin exp_err = 1; exp_rd = DEAD; resp_at = 1 + TIMEOUT; end
        exp_g = '0;
        exp_g[g] = 1'b1;

        drive_tables();
        i_req_valid        = vmask;
        i_rule_rdata_valid = '0;
        #1;
        chk("accept_ready", o_req_ready, exp_g);
        chk("accept_busy", o_busy, 1'b0);
        for (int c = 1; c <= resp_at; c++) begin
            @(posedge i_clk); #1;
            if (!hold) i_req_valid = '0;
            i_rule_rdata_valid = noise ? 4'($urandom) : 4'h0;
            for (int l = 0; l < 4; l++) i_rule_rdata[l] = $urandom;
            if (lay < 4) i_rule_rdata_valid[lay] = 1'b0;
            if (!wr && lay < 4 && c == 1 + dly) begin
                i_rule_rdata_valid[lay] = 1'b1;
                i_rule_rdata[lay]       = rdat;
            end
            #1;
            exp_wr  = '0;
            exp_rdn = '0;
            if (c == 1 && lay < 4) begin
                if (wr) exp_wr[lay]  = 1'b1;
                else    exp_rdn[lay] = 1'b1;
            end
            chk("busy_ready", o_req_ready, 2'b00);
            chk("busy_flag", o_busy, 1'b1);
            chk("rule_wren", o_rule_wren, exp_wr);
            chk("rule_rden", o_rule_rden, exp_rdn);
            if (c == 1) begin
                chk("rule_addr", o_rule_addr, {4'h0, a[27:0]});
                chk("rule_wdata", o_rule_wdata, t_wdata[g]);
            end
            chk("resp_valid", o_resp_valid, (c == resp_at) ? exp_g : 2'b00);
            if (c == resp_at) begin
                chk("resp_err", o_resp_err, exp_err);
                chk("resp_rdata", o_resp_rdata, exp_rd);
            end
        end
        m_rr = (g + 1) % 2;
        @(posedge i_clk); #1;
        i_rule_rdata_valid = '0;
        if (!hold) i_req_valid = '0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_req_valid = 2'b11;
        i_req_wr = '0; i_req_addr = '0; i_req_wdata = '0;
        i_rule_rdata_valid = '0; i_rule_rdata = '0;
        for (int k = 0; k < 2; k++) begin t_wr[k] = 0; t_addr[k] = '0; t_wdata[k] = '0; end

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", o_req_ready, 2'b00);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_wren", o_rule_wren, 4'h0);
        chk("rst_rden", o_rule_rden, 4'h0);
        chk("rst_addr", o_rule_addr, 32'h0);
        chk("rst_wdata", o_rule_wdata, 32'h0);
        chk("rst_resp_valid", o_resp_valid, 2'b00);
        chk("rst_resp_err", o_resp_err, 1'b0);
        chk("rst_resp_rdata", o_resp_rdata, 32'h0);
        i_rst = 1'b0;
        i_req_valid = '0;
        @(posedge i_clk); #1;

        t_wr[0] = 1; t_addr[0] = 32'h1000_0040; t_wdata[0] = 32'hA5A5_0001;
        txn(2'b01, 0, -1, 32'h0, 0);
        t_wr[1] = 0; t_addr[1] = 32'h2000_0008; t_wdata[1] = 32'h0;
        txn(2'b10, 0, 0, 32'h1234_5678, 1);
        t_wr[0] = 0; t_addr[0] = 32'h3000_0010;
        txn(2'b01, 0, -1, 32'h0, 1);
        txn(2'b01, 0, TIMEOUT - 1, 32'hCAFE_F00D, 0);
        txn(2'b10, 0, 5, 32'h0BAD_CAFE, 1);
        t_wr[1] = 1; t_addr[1] = 32'h7000_0000; t_wdata[1] = 32'h1111_2222;
        txn(2'b10, 0, -1, 32'h0, 0);

        t_wr[0] = 1; t_addr[0] = 32'h0000_0100; t_wdata[0] = 32'h0000_00AA;
        t_wr[1] = 1; t_addr[1] = 32'h1000_0200; t_wdata[1] = 32'h0000_00BB;
        for (int n = 0; n < 4; n++) txn(2'b11, 1, -1, 32'h0, 0);
        i_req_valid = '0;
        txn(2'b01, 0, -1, 32'h0, 0);

        t_wr[0] = 0; t_addr[0] = 32'h3000_0004;
        drive_tables();
        i_req_valid = 2'b01;
        #1;
        chk("mid_accept", o_req_ready, 2'b01);
        @(posedge i_clk); #1;
        i_req_valid = '0;
        #1;
        chk("mid_rden", o_rule_rden, 4'b1000);
        repeat (3) @(posedge i_clk);
        #1;
        chk("mid_busy", o_busy, 1'b1);
        i_rst = 1'b1;
        i_req_valid = 2'b11;
        #1;
        chk("mid_rst_busy", o_busy, 1'b0);
        chk("mid_rst_ready", o_req_ready, 2'b00);
        chk("mid_rst_rden", o_rule_rden, 4'h0);
        chk("mid_rst_resp", o_resp_valid, 2'b00);
        chk("mid_rst_addr", o_rule_addr, 32'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_req_valid = '0;
        @(posedge i_clk); #1;
        i_rule_rdata_valid = 4'b1000;
        i_rule_rdata[3] = 32'h5555_AAAA;
        #1;
        chk("late_ret_busy", o_busy, 1'b0);
        chk("late_ret_resp", o_resp_valid, 2'b00);
        @(posedge i_clk); #1;
        i_rule_rdata_valid = '0;
        #1;
        chk("late_ret_busy2", o_busy, 1'b0);
        chk("late_ret_resp2", o_resp_valid, 2'b00);
        m_rr = 0;
        t_wr[0] = 1; t_addr[0] = 32'h1000_0000; t_wdata[0] = 32'h0000_0001;
        t_wr[1] = 1; t_addr[1] = 32'h2000_0000; t_wdata[1] = 32'h0000_0002;
        @(posedge i_clk); #1;
        txn(2'b11, 0, -1, 32'h0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [1:0] vm;
            for (int k = 0; k < 2; k++) begin
                t_wr[k]    = 1'($urandom);
                t_addr[k]  = {4'($urandom_range(0, 5)), 28'($urandom)};
                t_wdata[k] = $urandom;
            end
            vm = 2'($urandom_range(1, 3));
            txn(vm, 1'($urandom), int'($urandom_range(0, 17)) - 1, $urandom, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parser_conf_arbiter.md
PARSER_CONF_ARBITER -- requirements
Module: parser_conf_arbiter

Interface
REQ-001 SHALL have parameters: REQ_NUM, default 2, number of config requesters; LAYER_NUM, default 4, number of parser layers; TIMEOUT, default 15, maximum read-wait cycles (4-bit counter).
REQ-002 SHALL have ports, clock and reset first:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req_valid  in  REQ_NUM  per-requester request valid
- i_req_wr  in  REQ_NUM  1=write, 0=read
- i_req_addr  in  REQ_NUM x 32  [31:28]=layer index, [27:0]=rule address
- i_req_wdata  in  REQ_NUM x 32  write data
- o_req_ready  out  REQ_NUM  one-hot accept strobe
- o_resp_valid  out  REQ_NUM  one-hot completion strobe
- o_resp_err  out  1  completion error flag, valid with o_resp_valid
- o_resp_rdata  out  32  read data, valid with o_resp_valid
- o_rule_wren  out  LAYER_NUM  per-layer write strobe
- o_rule_rden  out  LAYER_NUM  per-layer read strobe
- o_rule_addr  out  32  shared, {4'b0, addr[27:0]}
- o_rule_wdata  out  32  shared write data
- i_rule_rdata_valid  in  LAYER_NUM  per-layer read-return valid
- i_rule_rdata  in  LAYER_NUM x 32  per-layer read data
- o_busy  out  1  high whenever state != IDLE

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT_RD, RESP; at most one transaction outstanding.
REQ-004 IDLE: if any i_req_valid, SHALL grant one requester round-robin starting from rr_ptr, assert o_req_ready[grant] combinationally that cycle, latch wr/addr/wdata/grant, go to ISSUE; otherwise stay in IDLE with o_req_ready=0.
REQ-005 o_req_ready SHALL be 0 in all states except IDLE; a requester SHALL hold its request stable until it sees ready.
REQ-006 ISSUE, valid layer (index < LAYER_NUM): SHALL drive o_rule_wren[layer] (write) or o_rule_rden[layer] (read) high for exactly this one cycle, with o_rule_addr/o_rule_wdata valid in the same cycle; all other strobe bits 0.
REQ-007 ISSUE, write: SHALL go to RESP with err=0, rdata=0.
REQ-008 ISSUE or WAIT_RD, read: SHALL sample i_rule_rdata_valid[layer]; when it is 1, capture i_rule_rdata[layer] and go to RESP with err=0; valid bits of other layers SHALL be ignored.
REQ-009 ISSUE, read with no return: SHALL go to WAIT_RD with the wait counter at 1; WAIT_RD increments the counter each cycle without a return; the counter reaching TIMEOUT with no return SHALL go to RESP with err=1 and rdata=32'hDEADBEEF.
REQ-010 A return and the timeout in the same cycle: the return SHALL win (err=0).
REQ-011 Invalid layer index (>= LAYER_NUM): no strobe asserted; ISSUE goes to RESP with err=1 and rdata=32'hDEADBEEF.
REQ-012 RESP: SHALL pulse o_resp_valid[grant] for one cycle, with o_resp_err/o_resp_rdata registered and stable; SHALL set rr_ptr=(grant+1) mod REQ_NUM and return to IDLE.
REQ-013 Latency from accept cycle T: strobe at T+1; o_resp_valid at T+2 for writes and same-cycle reads; a read whose return arrives k cycles after the strobe completes at T+2+k.
REQ-014 A new request SHALL be accepted no earlier than the cycle after RESP; back-to-back throughput is one transaction per 3 cycles.
REQ-015 Round-robin SHALL be starvation-free: with all requesters continuously valid, grants rotate 0,1,...,REQ_NUM-1,0.

Reset
REQ-016 While i_rst=1, asynchronously: state=IDLE, rr_ptr=0, wait counter=0; o_rule_wren=0, o_rule_rden=0, o_rule_addr=0, o_rule_wdata=0, o_resp_valid=0, o_resp_err=0, o_resp_rdata=0, o_busy=0, o_req_ready=0.
REQ-017 Reset mid-transaction SHALL abandon it with no response; a late i_rule_rdata_valid after reset release SHALL be ignored in IDLE.

Verification
REQ-018 Write: req0 wr, addr=32'h1000_0040, wdata=32'hA5A5_0001 -> ready0 at T, o_rule_wren=4'b0010, o_rule_addr=32'h0000_0040 at T+1, resp_valid0 at T+2 with err=0.
REQ-019 Same-cycle read: req1 rd, addr=32'h2000_0008, layer 2 returns valid with 32'h1234_5678 in the strobe cycle -> resp_valid1 at T+2, rdata=32'h1234_5678, err=0.
REQ-020 Timeout: read to layer 3, never returns -> resp at T+1+TIMEOUT (T+16 at default), err=1, rdata=32'hDEADBEEF; no strobe repeated.
REQ-021 Fairness: req0 and req1 both held valid for 12 cycles -> grants alternate 0,1,0,1; with rr_ptr=1 after reset-free run, a simultaneous request grants 1 first.
REQ-022 Bad layer: addr=32'h7000_0000 -> no wren/rden asserted, resp at T+2, err=1.
REQ-023 Reset pulse during WAIT_RD -> all outputs 0 immediately, no resp_valid; next request served normally, starting from rr_ptr=0.
